// File: rtl/core_load_monitor.sv
// Per-core windowed busy-cycle monitor: scaled raw load, EMA-smoothed load and peak tracking.
// Latency: outputs update 1 cycle after a window's last sample (load_valid pulse); no backpressure, outputs only.
module core_load_monitor #(
  parameter int NUM_CORES          = 4,
  parameter int LOAD_MONITOR_WIDTH = 16,
  parameter int WINDOW_LOG2        = 10,
  parameter int EMA_SHIFT          = 2
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             monitor_enable,
  input  logic [NUM_CORES-1:0]                             core_active,
  input  logic [NUM_CORES-1:0]                             core_busy,
  input  logic                                             ema_clear,
  input  logic                                             peak_clear,
  output logic [NUM_CORES-1:0][LOAD_MONITOR_WIDTH-1:0]     core_load,
  output logic [NUM_CORES-1:0][LOAD_MONITOR_WIDTH-1:0]     core_load_raw,
  output logic [NUM_CORES-1:0][LOAD_MONITOR_WIDTH-1:0]     core_load_peak,
  output logic                                             load_valid,
  output logic [WINDOW_LOG2-1:0]                           window_phase
);

  localparam int LW = LOAD_MONITOR_WIDTH;
  localparam int W  = WINDOW_LOG2;
  localparam int SH = LW - W;

  logic [NUM_CORES-1:0][W:0]    busy_cnt;
  logic [NUM_CORES-1:0][W:0]    cnt_next;
  logic [NUM_CORES-1:0][LW-1:0] raw_next;
  logic [NUM_CORES-1:0][LW-1:0] ema_next;
  logic [NUM_CORES-1:0][LW-1:0] peak_next;
  logic [NUM_CORES-1:0]         busy_inc;
  logic                         terminal;

  assign terminal = monitor_enable && (window_phase == {W{1'b1}});
  assign busy_inc = core_busy & core_active & {NUM_CORES{monitor_enable}};

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    logic [W:0]           cnt_final;
    logic [LW:0]          scaled;
    logic [LW-1:0]        raw_val;
    logic signed [LW+1:0] diff;
    logic signed [LW+1:0] step;
    logic signed [LW+1:0] sum;

    // Terminal-cycle sample is folded in before scaling.
    assign cnt_final = busy_cnt[g] + (W+1)'(busy_inc[g]);
    assign scaled    = (LW+1)'(cnt_final) << SH;
    assign raw_val   = !core_active[g] ? '0 : (scaled[LW] ? '1 : scaled[LW-1:0]);

    // Two guard bits keep the signed difference exact; result stays within 0..max.
    assign diff = $signed({2'b00, raw_val}) - $signed({2'b00, core_load[g]});
    assign step = diff >>> EMA_SHIFT;
    assign sum  = $signed({2'b00, core_load[g]}) + step;

    assign cnt_next[g]  = cnt_final;
    assign raw_next[g]  = raw_val;
    assign ema_next[g]  = (!core_active[g] || ema_clear) ? raw_val : LW'(sum);
    assign peak_next[g] = (peak_clear || (raw_val > core_load_peak[g])) ? raw_val : core_load_peak[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt       <= '0;
      window_phase   <= '0;
      load_valid     <= 1'b0;
      core_load      <= '0;
      core_load_raw  <= '0;
      core_load_peak <= '0;
    end else begin
      load_valid <= terminal;

      if (!monitor_enable) begin
        window_phase <= '0;
        busy_cnt     <= '0;
      end else begin
        window_phase <= window_phase + W'(1);
        for (int i = 0; i < NUM_CORES; i++) begin
          busy_cnt[i] <= terminal ? '0 : cnt_next[i];
        end
      end

      if (terminal) begin
        core_load_raw  <= raw_next;
        core_load      <= ema_next;
        core_load_peak <= peak_next;
      end else begin
        if (ema_clear)  core_load      <= '0;
        if (peak_clear) core_load_peak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_core_load_monitor.sv
// Scoreboard bench for core_load_monitor with a 16-cycle window and EMA weight 1/4.
module tb_core_load_monitor;

  logic                 clk;
  logic                 rst;
  logic                 monitor_enable;
  logic [3:0]           core_active;
  logic [3:0]           core_busy;
  logic                 ema_clear;
  logic                 peak_clear;
  logic [3:0][15:0]     core_load;
  logic [3:0][15:0]     core_load_raw;
  logic [3:0][15:0]     core_load_peak;
  logic                 load_valid;
  logic [3:0]           window_phase;

  typedef struct packed {
    logic [63:0] load;
    logic [63:0] raw;
    logic [63:0] peak;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  core_load_monitor #(
    .NUM_CORES(4),
    .LOAD_MONITOR_WIDTH(16),
    .WINDOW_LOG2(4),
    .EMA_SHIFT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .monitor_enable(monitor_enable),
    .core_active(core_active),
    .core_busy(core_busy),
    .ema_clear(ema_clear),
    .peak_clear(peak_clear),
    .core_load(core_load),
    .core_load_raw(core_load_raw),
    .core_load_peak(core_load_peak),
    .load_valid(load_valid),
    .window_phase(window_phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] pk(input logic [15:0] c0, input logic [15:0] c1,
                                     input logic [15:0] c2, input logic [15:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pushes the expected result, then drives one full enabled window.
  task automatic run_window(input logic [63:0] busy, input logic [63:0] act,
                            input logic [15:0] pclr, input logic [15:0] eclr,
                            input logic [63:0] e_load, input logic [63:0] e_raw,
                            input logic [63:0] e_peak);
    exp_t e;
    e.load = e_load;
    e.raw  = e_raw;
    e.peak = e_peak;
    q.push_back(e);
    for (int k = 0; k < 16; k++) begin
      monitor_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
        core_busy[i]   = busy[16*i + k];
        core_active[i] = act[16*i + k];
      end
      peak_clear = pclr[k];
      ema_clear  = eclr[k];
      step();
      check("valid_timing", 64'(load_valid), 64'(k == 15));
    end
    peak_clear = 1'b0;
    ema_clear  = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && load_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: load_valid=1 with no expected entry");
      end else begin
        e = q.pop_front();
        check("sb_core_load", core_load, e.load);
        check("sb_core_load_raw", core_load_raw, e.raw);
        check("sb_core_load_peak", core_load_peak, e.peak);
        check("sb_phase_wrap", 64'(window_phase), 64'(0));
      end
    end
  end

  logic [63:0] act_std;
  logic [63:0] busy_std;

  initial begin
    rst            = 1'b0;
    monitor_enable = 1'b0;
    core_active    = '0;
    core_busy      = '0;
    ema_clear      = 1'b0;
    peak_clear     = 1'b0;
    act_std  = pk(16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF);
    busy_std = pk(16'hFFFF, 16'h00FF, 16'hFFFF, 16'h0000);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_load", core_load, 64'h0);
    check("reset_raw", core_load_raw, 64'h0);
    check("reset_peak", core_load_peak, 64'h0);
    check("reset_valid", 64'(load_valid), 64'h0);
    check("reset_phase", 64'(window_phase), 64'h0);
    rst = 1'b0;

    // Saturation, half load, inactive core with busy=1, idle core.
    run_window(busy_std, act_std, 16'h0, 16'h0,
               pk(16'h3FFF, 16'h2000, 0, 0), pk(16'hFFFF, 16'h8000, 0, 0), pk(16'hFFFF, 16'h8000, 0, 0));
    run_window(busy_std, act_std, 16'h0, 16'h0,
               pk(16'h6FFF, 16'h3800, 0, 0), pk(16'hFFFF, 16'h8000, 0, 0), pk(16'hFFFF, 16'h8000, 0, 0));

    // Enable dropped at phase 7: partial window discarded, outputs hold.
    for (int k = 0; k < 7; k++) begin
      monitor_enable = 1'b1;
      core_busy      = 4'hF;
      core_active    = 4'b1011;
      step();
    end
    check("phase_before_drop", 64'(window_phase), 64'd7);
    monitor_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("disabled_valid", 64'(load_valid), 64'h0);
      check("disabled_phase", 64'(window_phase), 64'h0);
    end
    check("hold_load", core_load, pk(16'h6FFF, 16'h3800, 0, 0));
    check("hold_raw", core_load_raw, pk(16'hFFFF, 16'h8000, 0, 0));
    check("hold_peak", core_load_peak, pk(16'hFFFF, 16'h8000, 0, 0));

    run_window(pk(16'hFFFF, 16'h000F, 16'hFFFF, 16'h0000), act_std, 16'h0, 16'h0,
               pk(16'h93FF, 16'h3A00, 0, 0), pk(16'hFFFF, 16'h4000, 0, 0), pk(16'hFFFF, 16'h8000, 0, 0));

    // Both clears coincident with the update edge seed EMA and peak with raw.
    run_window(pk(16'h000F, 16'h00FF, 16'hFFFF, 16'h0000), act_std, 16'h8000, 16'h8000,
               pk(16'h4000, 16'h8000, 0, 0), pk(16'h4000, 16'h8000, 0, 0), pk(16'h4000, 16'h8000, 0, 0));

    monitor_enable = 1'b0;
    ema_clear      = 1'b1;
    step();
    check("ema_clear_alone", core_load, 64'h0);
    check("peak_hold_on_ema_clear", core_load_peak, pk(16'h4000, 16'h8000, 0, 0));
    check("raw_hold_on_ema_clear", core_load_raw, pk(16'h4000, 16'h8000, 0, 0));
    ema_clear  = 1'b0;
    peak_clear = 1'b1;
    step();
    check("peak_clear_alone", core_load_peak, 64'h0);
    peak_clear = 1'b0;

    // Core3 active only for the second half: partial count stands.
    run_window(pk(16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF),
               pk(16'hFFFF, 16'hFFFF, 16'h0000, 16'hFF00), 16'h0, 16'h0,
               pk(16'h3FFF, 0, 0, 16'h2000), pk(16'hFFFF, 0, 0, 16'h8000), pk(16'hFFFF, 0, 0, 16'h8000));

    // Load falling: EMA steps down with arithmetic shift, peak holds.
    run_window(64'h0, act_std, 16'h0, 16'h0,
               pk(16'h2FFF, 0, 0, 16'h1800), 64'h0, pk(16'hFFFF, 0, 0, 16'h8000));

    // Asynchronous reset mid-window.
    for (int k = 0; k < 5; k++) begin
      monitor_enable = 1'b1;
      core_busy      = 4'hF;
      core_active    = 4'b1011;
      step();
    end
    #3 rst = 1'b1;
    #1;
    check("async_rst_load", core_load, 64'h0);
    check("async_rst_raw", core_load_raw, 64'h0);
    check("async_rst_peak", core_load_peak, 64'h0);
    check("async_rst_phase", 64'(window_phase), 64'h0);
    check("async_rst_valid", 64'(load_valid), 64'h0);
    step();
    rst = 1'b0;
    run_window(busy_std, act_std, 16'h0, 16'h0,
               pk(16'h3FFF, 16'h2000, 0, 0), pk(16'hFFFF, 16'h8000, 0, 0), pk(16'hFFFF, 16'h8000, 0, 0));

    monitor_enable = 1'b0;
    repeat (3) step();
    check("scoreboard_drain", 64'(q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_load_monitor.md
Name: core_load_monitor

Overview:
Upstream feeder of the DVFS policy engine. Per-core windowed utilisation monitor:
- counts busy cycles of each core over a fixed power-of-two window;
- scales each count to a 16-bit load fraction and smooths it with an exponential moving average (EMA);
- drives the DVFS controller's per-core load inputs and tracks per-core peak load for software/telemetry.

Parameters:
NUM_CORES, 4, number of monitored cores
LOAD_MONITOR_WIDTH, 16, width of load outputs (fixed-point fraction, 0xFFFF = 100%)
WINDOW_LOG2, 10, window length = 2^WINDOW_LOG2 cycles; legal range 1..LOAD_MONITOR_WIDTH
EMA_SHIFT, 2, EMA weight = 2^-EMA_SHIFT; legal range 0..4 (0 = no smoothing)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
monitor_enable  input  1  run window counting
core_active  input  NUM_CORES  core powered/active
core_busy  input  NUM_CORES  per-cycle busy indication (retire or stall-on-work)
ema_clear  input  1  synchronous clear of EMA state
peak_clear  input  1  synchronous clear of peak registers
core_load  output  [NUM_CORES][LOAD_MONITOR_WIDTH]  smoothed load, feeds DVFS core_load
core_load_raw  output  [NUM_CORES][LOAD_MONITOR_WIDTH]  last window's unsmoothed load
core_load_peak  output  [NUM_CORES][LOAD_MONITOR_WIDTH]  max raw load since last peak_clear
load_valid  output  1  one-cycle pulse when outputs update
window_phase  output  WINDOW_LOG2  current window cycle index

Behaviour:
Reset (rst high, async):
- all counters, core_load, core_load_raw, core_load_peak, window_phase and load_valid = 0.

Window counter:
- counts 0..2^W-1 while monitor_enable = 1, wraps to 0.
- monitor_enable = 0: window counter and busy counters clear to 0; load/raw/peak outputs hold; load_valid = 0.
- Re-enable starts a fresh full window at phase 0.

Busy counters:
- W+1 bits per core; increment when core_busy[i] & core_active[i] & monitor_enable.
- The sample at the terminal cycle (phase = 2^W-1) is included in that window's count.
- The counter then restarts with the next cycle's sample (restart value 0, or 1 if that cycle is busy).

Scaling:
- raw = count << (LOAD_MONITOR_WIDTH-W).
- count = 2^W (all busy) saturates to 0xFFFF.
- W = LOAD_MONITOR_WIDTH: raw = count, saturated at 0xFFFF.

Update timing and ordering:
- Update occurs at the clock edge ending the terminal cycle; outputs are visible the following cycle.
- load_valid is high for exactly that one cycle.
- Latency: last sample to new output = 1 cycle.

EMA:
- ema_next = ema + ((raw - ema) >>> EMA_SHIFT).
- Computed in LOAD_MONITOR_WIDTH+2-bit signed arithmetic, then truncated back; the result is always within 0..0xFFFF.
- core_load = ema.

Inactive cores:
- A core with core_active[i] = 0 at the update edge has raw and EMA forced to 0; its peak holds.
- core_active dropping mid-window stops its counting; the partial count stands if it is active again at the update edge.

Peak:
- On update, peak = max(peak, raw).
- peak_clear alone sets peak to 0.
- peak_clear coincident with an update sets peak = raw of the new window.

EMA clear:
- ema_clear alone sets EMA to 0.
- ema_clear coincident with an update sets EMA = raw (seed, no smoothing).

Reset mid-window:
- Discards the partial window; the first update after reset release occurs 2^W enabled cycles later.

Test Plan:
- W=4, EMA_SHIFT=2, core0 busy all 16 cycles from reset -> raw 0xFFFF (saturated), core_load 0x3FFF, peak 0xFFFF, load_valid one pulse at cycle 17.
- W=4, core1 busy 8 of 16 cycles for two windows -> raw 0x8000 both windows; core_load 0x2000 then 0x3800; peak 0x8000.
- Core2 core_active=0 throughout with core_busy=1 -> core_load/raw 0 every window; peak stays 0.
- monitor_enable dropped at phase 7 then restored -> no load_valid until 16 cycles after restore; outputs hold prior values meanwhile.
- peak_clear and ema_clear asserted on the update edge with raw 0x4000 (prior peak 0xFFFF, EMA 0x3FFF) -> peak 0x4000, core_load 0x4000.
- rst asserted asynchronously mid-window with nonzero outputs -> all outputs 0 immediately; next load_valid exactly 16 enabled cycles after release.
